pcie_msi_sequencer: RTL and testbench

Sits directly downstream of the PCIe interrupt manager. It consumes the manager's level-sensitive IRQ_REQ and runs the MSI request/grant handshake with the AXI-PCIe bridge. It returns a one-cycle IRQ_ACK to the manager for each MSI the bridge grants. It also enforces a holdoff between MSIs, optionally re-fires while IRQ_REQ stays high, and recovers from grants that never arrive.

---
 rtl/pcie_msi_sequencer.sv | 125 ++++++++++++
 tb/tb_pcie_msi_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_msi_sequencer.sv
// Turns the interrupt manager's level request into single MSI request/grant
// handshakes with the AXI-PCIe bridge, with holdoff, re-arm control and a grant timeout.
module pcie_msi_sequencer #(
   parameter logic [4:0]  MSI_VECTOR     = 5'd0,
   parameter int unsigned HOLDOFF_CYCLES = 250,
   parameter int unsigned GRANT_TIMEOUT  = 1000,
   parameter bit          REARM          = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        IRQ_REQ,
   output logic        IRQ_ACK,
   input  logic        MSI_ENABLE,
   output logic        INTX_MSI_REQUEST,
   input  logic        INTX_MSI_GRANT,
   output logic [4:0]  MSI_VECTOR_NUM,
   output logic [15:0] TIMEOUT_COUNT,
   output logic        BUSY
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQUEST = 2'd1;
   localparam logic [1:0] ST_WAIT    = 2'd2;
   localparam logic [1:0] ST_HOLDOFF = 2'd3;

   localparam logic [15:0] HOLDOFF_LIM = 16'(HOLDOFF_CYCLES);
   localparam logic [15:0] TIMEOUT_LIM = 16'(GRANT_TIMEOUT);

   logic [1:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] tmo_q, tmo_d;
   logic        armed_q, armed_d;
   logic        ack_q, ack_d;
   logic        req_q, req_d;
   logic        busy_q, busy_d;
   logic        start_s;
   logic [15:0] cnt_inc_s;

   assign start_s   = (state_q == ST_IDLE) && IRQ_REQ && MSI_ENABLE && armed_q;
   assign cnt_inc_s = cnt_q + 16'd1;

   // A low IRQ_REQ re-arms in any state; without REARM, launching a request disarms.
   assign armed_d = REARM || !IRQ_REQ || (armed_q && !start_s);

   // Next-state logic; cnt_q is the wait counter in WAIT and the holdoff counter in HOLDOFF.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      ack_d   = 1'b0;
      req_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               state_d = ST_REQUEST;
               req_d   = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQUEST: begin
            state_d = ST_WAIT;
            cnt_d   = 16'd0;
         end
         ST_WAIT: begin
            if (INTX_MSI_GRANT) begin
               ack_d   = 1'b1;
               state_d = ST_HOLDOFF;
               cnt_d   = 16'd0;
            end else if (cnt_inc_s >= TIMEOUT_LIM) begin
               state_d = ST_HOLDOFF;
               cnt_d   = 16'd0;
               if (tmo_q != 16'hFFFF) begin
                  tmo_d = tmo_q + 16'd1;
               end else begin
                  tmo_d = tmo_q;
               end
            end else begin
               cnt_d = cnt_inc_s;
            end
         end
         ST_HOLDOFF: begin
            if (cnt_q >= HOLDOFF_LIM) begin
               state_d = ST_IDLE;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= 16'd0;
         tmo_q   <= 16'd0;
         armed_q <= 1'b1;
         ack_q   <= 1'b0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         armed_q <= armed_d;
         ack_q   <= ack_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
      end
   end

   assign IRQ_ACK          = ack_q;
   assign INTX_MSI_REQUEST = req_q;
   assign TIMEOUT_COUNT    = tmo_q;
   assign BUSY             = busy_q;
   assign MSI_VECTOR_NUM   = MSI_VECTOR;

endmodule

// File: tb/tb_pcie_msi_sequencer.sv
// Scoreboard bench: two sequencers (REARM=1 and REARM=0, holdoff 4, timeout 8)
// driven by directed stimulus with hand-computed request/ack cycles.
module tb_pcie_msi_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn;
   logic        irq_a, en_a, ack_a, req_a, busy_a, gnt_a;
   logic        irq_b, en_b, ack_b, req_b, busy_b, gnt_b;
   logic [4:0]  vec_a, vec_b;
   logic [15:0] tmo_a, tmo_b;
   logic        gnt_a_auto = 1'b0, gnt_a_man = 1'b0;
   logic        gnt_b_auto = 1'b0, gnt_b_man = 1'b0;

   assign gnt_a = gnt_a_auto | gnt_a_man;
   assign gnt_b = gnt_b_auto | gnt_b_man;

   pcie_msi_sequencer #(.MSI_VECTOR(5'd19), .HOLDOFF_CYCLES(4), .GRANT_TIMEOUT(8), .REARM(1'b1)) dut_a (
      .clk(clk), .resetn(resetn), .IRQ_REQ(irq_a), .IRQ_ACK(ack_a), .MSI_ENABLE(en_a),
      .INTX_MSI_REQUEST(req_a), .INTX_MSI_GRANT(gnt_a), .MSI_VECTOR_NUM(vec_a),
      .TIMEOUT_COUNT(tmo_a), .BUSY(busy_a));

   pcie_msi_sequencer #(.MSI_VECTOR(5'd0), .HOLDOFF_CYCLES(4), .GRANT_TIMEOUT(8), .REARM(1'b0)) dut_b (
      .clk(clk), .resetn(resetn), .IRQ_REQ(irq_b), .IRQ_ACK(ack_b), .MSI_ENABLE(en_b),
      .INTX_MSI_REQUEST(req_b), .INTX_MSI_GRANT(gnt_b), .MSI_VECTOR_NUM(vec_b),
      .TIMEOUT_COUNT(tmo_b), .BUSY(busy_b));

   typedef struct {
      bit is_ack;
      int cyc;
   } ev_t;

   ev_t qa[$];
   ev_t qb[$];
   int  cyc = 0;
   int  n_chk = 0;
   int  n_fail = 0;
   int  dly_a = 0, dly_b = 0;
   int  gnt_at_a = -1, gnt_at_b = -1;

   // cycle k is the period following the k-th rising edge
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic go(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic mon_dut(input string tag, input logic rq, input logic ak, input int c, ref ev_t q[$]);
      ev_t e;
      if (rq || ak) begin
         chk({tag, " req_ack_exclusive"}, int'(rq && ak), 0);
         chk({tag, " expected_event_pending"}, int'(q.size() != 0), 1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk({tag, " event_is_ack"}, int'(ak), int'(e.is_ack));
            chk({tag, " event_cycle"}, c, e.cyc);
         end
      end
   endtask

   // Bridge model: one-cycle grant a fixed number of cycles after each request pulse.
   always @(posedge clk) begin
      #1;
      gnt_a_auto = (cyc == gnt_at_a);
      gnt_b_auto = (cyc == gnt_at_b);
   end

   always @(negedge clk) begin
      if (req_a && dly_a > 0) gnt_at_a = cyc + dly_a;
      if (req_b && dly_b > 0) gnt_at_b = cyc + dly_b;
      mon_dut("A", req_a, ack_a, cyc, qa);
      mon_dut("B", req_b, ack_b, cyc, qb);
   end

   initial begin
      resetn = 1'b0;
      irq_a = 1'b0; en_a = 1'b1;
      irq_b = 1'b0; en_b = 1'b1;
      go(1);
      chk("reset busy_a", busy_a, 0);
      chk("reset req_a", req_a, 0);
      chk("reset ack_a", ack_a, 0);
      chk("reset tmo_a", tmo_a, 0);
      chk("reset busy_b", busy_b, 0);
      chk("vector_a", vec_a, 19);
      chk("vector_b", vec_b, 0);
      go(2);
      resetn = 1'b1;

      // basic grant, grant 3 cycles after request
      dly_a = 3;
      for (int c = 10; c <= 21; c++) begin
         go(c);
         if (c == 10) begin
            irq_a = 1'b1;
            qa.push_back('{1'b0, 11});
            qa.push_back('{1'b1, 15});
         end
         if (c == 16) irq_a = 1'b0;
         chk($sformatf("t1 busy c%0d", c), busy_a, int'(c >= 11 && c <= 19));
      end

      // re-fire every 9 cycles while IRQ_REQ is held
      dly_a = 2;
      go(30);
      irq_a = 1'b1;
      for (int k = 0; k < 4; k++) begin
         qa.push_back('{1'b0, 31 + 9 * k});
         qa.push_back('{1'b1, 34 + 9 * k});
      end
      go(59);
      irq_a = 1'b0;
      go(75);
      chk("t2 events consumed", qa.size(), 0);
      chk("t2 idle", busy_a, 0);

      // timeout after 8 wait cycles, then grant exactly on the 8th
      dly_a = 0;
      go(80);
      irq_a = 1'b1;
      qa.push_back('{1'b0, 81});
      go(89);
      chk("t4 tmo before", tmo_a, 0);
      go(90);
      chk("t4 tmo after", tmo_a, 1);
      chk("t4 holdoff busy", busy_a, 1);
      irq_a = 1'b0;
      dly_a = 8;
      go(100);
      irq_a = 1'b1;
      qa.push_back('{1'b0, 101});
      qa.push_back('{1'b1, 110});
      go(110);
      irq_a = 1'b0;
      go(111);
      chk("t4 grant wins tmo", tmo_a, 1);

      // MSI disabled holds the request pending; stray grant in IDLE ignored
      dly_a = 2;
      go(120);
      en_a = 1'b0;
      irq_a = 1'b1;
      go(130); chk("t5 busy c130", busy_a, 0);
      go(150); chk("t5 busy c150", busy_a, 0);
      go(169); chk("t5 busy c169", busy_a, 0);
      go(170);
      en_a = 1'b1;
      qa.push_back('{1'b0, 171});
      qa.push_back('{1'b1, 174});
      go(171); chk("t5 request next cycle", req_a, 1);
      go(174); irq_a = 1'b0;
      go(182); gnt_a_man = 1'b1;
      go(183); gnt_a_man = 1'b0;
      chk("t5 stray grant ack", ack_a, 0);
      go(186); chk("t5 stray grant busy", busy_a, 0);

      // REARM=0: one request per high phase, re-arm only after IRQ_REQ is seen low
      dly_b = 2;
      go(190);
      irq_b = 1'b1;
      qb.push_back('{1'b0, 191});
      qb.push_back('{1'b1, 194});
      go(290);
      chk("t3 idle while held", busy_b, 0);
      irq_b = 1'b0;
      go(291);
      irq_b = 1'b1;
      qb.push_back('{1'b0, 292});
      qb.push_back('{1'b1, 295});
      go(296); irq_b = 1'b0;
      go(305);
      irq_b = 1'b1;
      qb.push_back('{1'b0, 306});
      qb.push_back('{1'b1, 309});
      go(310); irq_b = 1'b0;
      go(311); irq_b = 1'b1;
      qb.push_back('{1'b0, 315});
      qb.push_back('{1'b1, 318});
      go(314); chk("t3 wait for holdoff", req_b, 0);
      go(318); irq_b = 1'b0;
      go(325);
      chk("t3 events consumed", qb.size(), 0);

      // asynchronous reset in WAIT_GRANT
      dly_a = 0;
      go(330);
      irq_a = 1'b1;
      qa.push_back('{1'b0, 331});
      go(333);
      chk("t6 busy before reset", busy_a, 1);
      chk("t6 tmo before reset", tmo_a, 1);
      go(334);
      irq_a = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      chk("t6 async busy", busy_a, 0);
      chk("t6 async tmo", tmo_a, 0);
      chk("t6 async req", req_a, 0);
      go(337);
      resetn = 1'b1;
      go(339); gnt_a_man = 1'b1;
      go(340); gnt_a_man = 1'b0;
      chk("t6 grant after reset ack", ack_a, 0);
      go(342);
      chk("t6 busy after release", busy_a, 0);
      chk("t6 tmo after release", tmo_a, 0);

      go(350);
      chk("final queue A empty", qa.size(), 0);
      chk("final queue B empty", qb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
